// File: rtl/cpu.sv
// Single-cycle 16-bit accumulator processor: fetch, decode and execute in one clock.
// Program ROM and data RAM are external, both read combinationally.
module cpu (
    input  logic        clk,
    input  logic        reset,
    output logic [10:0] addr_program,
    input  logic [15:0] data,
    output logic        rd,
    output logic        wr,
    output logic [10:0] addr_data,
    input  logic [15:0] in_data,
    output logic [15:0] out_data,
    output logic [15:0] acc
);

    typedef enum logic [4:0] {
        OP_HLT  = 5'b00000,
        OP_STO  = 5'b00001,
        OP_LD   = 5'b00010,
        OP_LDI  = 5'b00011,
        OP_ADD  = 5'b00100,
        OP_ADDI = 5'b00101,
        OP_SUB  = 5'b00110,
        OP_SUBI = 5'b00111
    } opcode_t;

    function automatic logic [15:0] sext11(input logic [10:0] value);
        sext11 = {{5{value[10]}}, value};
    endfunction

    logic [10:0] r_pc;
    logic [15:0] r_acc;

    logic [4:0]  w_opcode;
    logic [10:0] w_operand;
    logic [15:0] w_imm;
    logic [10:0] w_pc_next;
    logic [15:0] w_acc_next;
    logic        w_rd;
    logic        w_wr;

    assign w_opcode  = data[15:11];
    assign w_operand = data[10:0];
    assign w_imm     = sext11(w_operand);

    // Decode the current instruction into next-state values and memory strobes.
    always_comb begin
        w_pc_next  = r_pc + 11'd1;
        w_acc_next = r_acc;
        w_rd       = 1'b0;
        w_wr       = 1'b0;
        case (w_opcode)
            OP_HLT:  w_pc_next  = r_pc;
            OP_STO:  w_wr       = 1'b1;
            OP_LD: begin
                w_rd       = 1'b1;
                w_acc_next = in_data;
            end
            OP_LDI:  w_acc_next = w_imm;
            OP_ADD: begin
                w_rd       = 1'b1;
                w_acc_next = r_acc + in_data;
            end
            OP_ADDI: w_acc_next = r_acc + w_imm;
            OP_SUB: begin
                w_rd       = 1'b1;
                w_acc_next = r_acc - in_data;
            end
            OP_SUBI: w_acc_next = r_acc - w_imm;
            default: w_acc_next = r_acc;
        endcase
    end

    // PC and accumulator; reset overrides whatever instruction is on the bus.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc  <= 11'd0;
            r_acc <= 16'd0;
        end else begin
            r_pc  <= w_pc_next;
            r_acc <= w_acc_next;
        end
    end

    // Strobes are suppressed while reset is held so memory is never touched.
    assign rd           = w_rd & reset;
    assign wr           = w_wr & reset;
    assign addr_program = r_pc;
    assign addr_data    = w_operand;
    assign out_data     = r_acc;
    assign acc          = r_acc;

endmodule

// File: tb/tb_cpu.sv
// Directed self-checking bench for the single-cycle accumulator cpu.
module tb_cpu;

    logic        clk;
    logic        reset;
    logic [10:0] addr_program;
    logic [15:0] data;
    logic        rd;
    logic        wr;
    logic [10:0] addr_data;
    logic [15:0] in_data;
    logic [15:0] out_data;
    logic [15:0] acc;

    int checks = 0;
    int errors = 0;

    cpu dut (
        .clk          (clk),
        .reset        (reset),
        .addr_program (addr_program),
        .data         (data),
        .rd           (rd),
        .wr           (wr),
        .addr_data    (addr_data),
        .in_data      (in_data),
        .out_data     (out_data),
        .acc          (acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        data  = 16'hF800;
        tick();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        data    = 16'h1234;
        in_data = 16'h5555;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (addr_program !== 11'd0) begin errors++; $display("FAIL reset_pc got %0d want 0", addr_program); end
        checks++;
        if (acc !== 16'd0 || out_data !== 16'd0) begin errors++; $display("FAIL reset_acc got %h/%h want 0000", acc, out_data); end
        checks++;
        if (rd !== 1'b0 || wr !== 1'b0) begin errors++; $display("FAIL reset_strobes got rd=%b wr=%b want 0 0", rd, wr); end
        checks++;
        if (addr_data !== 11'h234) begin errors++; $display("FAIL reset_addr_data got %h want 234", addr_data); end
        reset = 1'b1;
        data  = 16'hF800;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (addr_program !== 11'(i)) begin errors++; $display("FAIL release_count got %0d want %0d", addr_program, i); end
        end
    endtask

    task automatic test_load_add_store();
        do_reset();
        data    = 16'h1001;
        in_data = 16'd7;
        #1;
        checks++;
        if (rd !== 1'b1 || wr !== 1'b0 || addr_data !== 11'd1) begin
            errors++; $display("FAIL ld_decode got rd=%b wr=%b addr=%0d want 1 0 1", rd, wr, addr_data);
        end
        tick();
        checks++;
        if (acc !== 16'd7) begin errors++; $display("FAIL ld_result got %h want 0007", acc); end
        data    = 16'h2805;
        in_data = 16'hBEEF;
        tick();
        checks++;
        if (acc !== 16'd12) begin errors++; $display("FAIL addi_result got %h want 000c", acc); end
        data = 16'h0808;
        #1;
        checks++;
        if (wr !== 1'b1 || rd !== 1'b0 || addr_data !== 11'd8 || out_data !== 16'd12) begin
            errors++; $display("FAIL sto_decode got wr=%b rd=%b addr=%0d out=%h want 1 0 8 000c", wr, rd, addr_data, out_data);
        end
        tick();
        checks++;
        if (acc !== 16'd12 || addr_program !== 11'd3) begin
            errors++; $display("FAIL sto_after got acc=%h pc=%0d want 000c 3", acc, addr_program);
        end
        data = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (addr_program !== 11'd3 || acc !== 16'd12 || rd !== 1'b0 || wr !== 1'b0) begin
                errors++; $display("FAIL hlt_hold got pc=%0d acc=%h rd=%b wr=%b want 3 000c 0 0", addr_program, acc, rd, wr);
            end
        end
    endtask

    task automatic test_reset_during_hlt();
        reset = 1'b0;
        data  = 16'h0000;
        tick();
        checks++;
        if (addr_program !== 11'd0 || acc !== 16'd0) begin
            errors++; $display("FAIL hlt_reset got pc=%0d acc=%h want 0 0000", addr_program, acc);
        end
        reset = 1'b1;
        data  = 16'h1805;
        tick();
        checks++;
        if (addr_program !== 11'd1 || acc !== 16'd5) begin
            errors++; $display("FAIL hlt_resume got pc=%0d acc=%h want 1 0005", addr_program, acc);
        end
    endtask

    task automatic test_sign_ext_wrap();
        logic [15:0] words [4]    = '{16'h1FFF, 16'h2801, 16'h3801, 16'h1BFF};
        logic [15:0] expect_v [4] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h03FF};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            data = words[i];
            tick();
            checks++;
            if (acc !== expect_v[i]) begin errors++; $display("FAIL sext_step%0d got %h want %h", i, acc, expect_v[i]); end
        end
    endtask

    task automatic test_mem_arith();
        do_reset();
        data = 16'h180A;
        tick();
        data    = 16'h2005;
        in_data = 16'hFFF6;
        #1;
        checks++;
        if (rd !== 1'b1 || wr !== 1'b0) begin errors++; $display("FAIL add_strobes got rd=%b wr=%b want 1 0", rd, wr); end
        tick();
        checks++;
        if (acc !== 16'h0000) begin errors++; $display("FAIL add_result got %h want 0000", acc); end
        data    = 16'h3003;
        in_data = 16'd3;
        #1;
        checks++;
        if (rd !== 1'b1 || wr !== 1'b0 || addr_data !== 11'd3) begin
            errors++; $display("FAIL sub_strobes got rd=%b wr=%b addr=%0d want 1 0 3", rd, wr, addr_data);
        end
        tick();
        checks++;
        if (acc !== 16'hFFFD) begin errors++; $display("FAIL sub_result got %h want fffd", acc); end
    endtask

    task automatic test_pc_wrap_nop();
        do_reset();
        data = 16'h1855;
        tick();
        data = 16'hF800;
        for (int i = 0; i < 2045; i++) tick();
        checks++;
        if (addr_program !== 11'd2046) begin errors++; $display("FAIL nop_pc_2046 got %0d want 2046", addr_program); end
        checks++;
        if (rd !== 1'b0 || wr !== 1'b0) begin errors++; $display("FAIL nop_strobes got rd=%b wr=%b want 0 0", rd, wr); end
        tick();
        checks++;
        if (addr_program !== 11'd2047 || acc !== 16'h0055) begin
            errors++; $display("FAIL nop_pc_2047 got pc=%0d acc=%h want 2047 0055", addr_program, acc);
        end
        tick();
        checks++;
        if (addr_program !== 11'd0 || acc !== 16'h0055) begin
            errors++; $display("FAIL pc_wrap got pc=%0d acc=%h want 0 0055", addr_program, acc);
        end
    endtask

    task automatic test_reset_mid_program();
        do_reset();
        data = 16'h2801;
        tick();
        tick();
        checks++;
        if (addr_program !== 11'd2 || acc !== 16'd2) begin
            errors++; $display("FAIL mid_pre got pc=%0d acc=%h want 2 0002", addr_program, acc);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (rd !== 1'b0 || wr !== 1'b0) begin errors++; $display("FAIL mid_strobes got rd=%b wr=%b want 0 0", rd, wr); end
        tick();
        checks++;
        if (addr_program !== 11'd0 || acc !== 16'd0) begin
            errors++; $display("FAIL mid_reset got pc=%0d acc=%h want 0 0000", addr_program, acc);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (addr_program !== 11'd1 || acc !== 16'd1) begin
            errors++; $display("FAIL mid_resume got pc=%0d acc=%h want 1 0001", addr_program, acc);
        end
    endtask

    initial begin
        reset   = 1'b0;
        data    = 16'h0000;
        in_data = 16'h0000;
        test_reset();
        test_load_add_store();
        test_reset_during_hlt();
        test_sign_ext_wrap();
        test_mem_arith();
        test_pc_wrap_nop();
        test_reset_mid_program();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
